// File: rtl/mux_8_1.sv
// 8:1 data selector with active-high tri-state output enable and a registered copy
// of the selected value for synchronous consumers.
module mux_8_1 #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_0_In,
  input  logic [DATA_WIDTH-1:0] Data_1_In,
  input  logic [DATA_WIDTH-1:0] Data_2_In,
  input  logic [DATA_WIDTH-1:0] Data_3_In,
  input  logic [DATA_WIDTH-1:0] Data_4_In,
  input  logic [DATA_WIDTH-1:0] Data_5_In,
  input  logic [DATA_WIDTH-1:0] Data_6_In,
  input  logic [DATA_WIDTH-1:0] Data_7_In,
  input  logic [2:0]            Select_In,
  output wire  [DATA_WIDTH-1:0] MUX_Result_Data_Out,
  output logic [DATA_WIDTH-1:0] MUX_Result_Reg_Out
);

  // Kept by this name so it can be probed during debug.
  logic [DATA_WIDTH-1:0] MUX_Data_Selected;
  logic                  drive_en;

  always_comb begin
    MUX_Data_Selected = '0;
    case (Select_In)
      3'd0:    MUX_Data_Selected = Data_0_In;
      3'd1:    MUX_Data_Selected = Data_1_In;
      3'd2:    MUX_Data_Selected = Data_2_In;
      3'd3:    MUX_Data_Selected = Data_3_In;
      3'd4:    MUX_Data_Selected = Data_4_In;
      3'd5:    MUX_Data_Selected = Data_5_In;
      3'd6:    MUX_Data_Selected = Data_6_In;
      3'd7:    MUX_Data_Selected = Data_7_In;
      default: MUX_Data_Selected = '0;
    endcase
  end

  // An unknown enable falls to the default arm, so the output floats.
  always_comb begin
    drive_en = 1'b0;
    case (Enable_In)
      1'b1:    drive_en = 1'b1;
      default: drive_en = 1'b0;
    endcase
  end

  assign MUX_Result_Data_Out = drive_en ? MUX_Data_Selected : {DATA_WIDTH{1'bz}};

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      MUX_Result_Reg_Out <= '0;
    end else if (Enable_In) begin
      MUX_Result_Reg_Out <= MUX_Data_Selected;
    end
  end

endmodule

// File: tb/tb_mux_8_1.sv
// Scoreboard bench for mux_8_1: expected combinational and registered results are
// queued as stimulus is applied and popped when the DUT outputs are sampled.
module tb_mux_8_1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] data  = 8'h00;
  logic [2:0] sel   = 3'd0;
  wire        out_comb;
  logic       out_reg;

  logic       comb_is_z;
  logic       comb_val;
  assign comb_is_z = (out_comb === 1'bz);
  assign comb_val  = out_comb;

  typedef struct {
    logic z;
    logic v;
  } exp_t;

  exp_t comb_q[$];
  logic reg_q[$];
  logic model_reg = 1'b0;
  int   errors    = 0;
  int   checks    = 0;

  mux_8_1 #(.DATA_WIDTH(1)) dut (
    .Clock_In            (clk),
    .Reset_n_In          (rst_n),
    .Enable_In           (en),
    .Data_0_In           (data[0]),
    .Data_1_In           (data[1]),
    .Data_2_In           (data[2]),
    .Data_3_In           (data[3]),
    .Data_4_In           (data[4]),
    .Data_5_In           (data[5]),
    .Data_6_In           (data[6]),
    .Data_7_In           (data[7]),
    .Select_In           (sel),
    .MUX_Result_Data_Out (out_comb),
    .MUX_Result_Reg_Out  (out_reg)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_comb(input logic e, input logic [7:0] d, input logic [2:0] s);
    exp_t x;
    x.z = (e !== 1'b1);
    x.v = d[s];
    comb_q.push_back(x);
  endtask

  task automatic check_comb(input string tag);
    exp_t x;
    x = comb_q.pop_front();
    if (x.z) check_val({tag, "_z"}, {7'b0, comb_is_z}, 8'd1);
    else     check_val(tag, {6'b0, comb_is_z, comb_val}, {7'b0, x.v});
  endtask

  // Drive one vector after a falling edge, check the combinational result, then
  // check the register one rising edge later.
  task automatic step(input logic e, input logic [7:0] d, input logic [2:0] s, input string tag);
    logic exp_r;
    @(negedge clk);
    en   = e;
    data = d;
    sel  = s;
    push_comb(e, d, s);
    #2 check_comb(tag);
    if (!rst_n)   model_reg = 1'b0;
    else if (e)   model_reg = d[s];
    reg_q.push_back(model_reg);
    @(posedge clk);
    #1;
    exp_r = reg_q.pop_front();
    check_val({tag, "_reg"}, {7'b0, out_reg}, {7'b0, exp_r});
  endtask

  logic [7:0] a5 = 8'hA5;
  logic [7:0] one_hot;

  initial begin
    #1;
    check_val("reset_reg", {7'b0, out_reg}, 8'd0);
    push_comb(1'b0, data, sel);
    check_comb("reset_comb");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      step(1'b0, 8'($urandom), 3'($urandom), "oe_off");

    for (int s = 0; s < 8; s++) begin
      one_hot = 8'b1 << s;
      step(1'b1, one_hot, 3'(s), "onehot");
      step(1'b1, ~one_hot, 3'(s), "onecold");
    end

    for (int s = 0; s < 8; s++) begin
      check_val("a5_pattern", {7'b0, a5[s]}, (s == 1 || s == 3 || s == 4 || s == 6) ? 8'd0 : 8'd1);
      step(1'b1, 8'hA5, 3'(s), "a5");
    end

    step(1'b1, 8'h80, 3'd7, "pre_rst");
    @(posedge clk);
    #5 rst_n = 1'b0;
    model_reg = 1'b0;
    #1 check_val("async_rst_reg", {7'b0, out_reg}, 8'd0);
    push_comb(en, data, sel);
    check_comb("rst_comb_live");
    step(1'b1, 8'h80, 3'd7, "rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h80, 3'd7, "post_rst");

    step(1'b1, 8'h01, 3'd0, "load_hold");
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'(i * 37 + 2), 3'(i), "hold");

    for (int i = 0; i < 10; i++)
      step(1'($urandom), 8'($urandom), 3'($urandom), "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
